// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: a Moore FSM that sequences each instruction
// over 3-5 states. It drives the shared-memory datapath (PC, IR, register file,
// ALU operand muxes, memory port) and traps unknown opcodes.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   opcode             IR[31:26]; only looked at in DECODE and MEMADR
//   zero               ALU zero flag. The PC write gating is done in the datapath.
//   mem_ready          memory access completes this cycle (FETCH/MEMRD/MEMWR only)
//   pcwrite            unconditional PC load
//   pcwritecond        PC load qualified by zero
//   iord               memory address source (0 = PC, 1 = ALUOut)
//   memread, memwrite  memory strobes
//   irwrite            IR load
//   memtoreg           write-back data comes from MDR
//   regdst             00 = rt, 01 = rd, 10 = $31
//   regwrite           register file write enable
//   alusrca            0 = PC, 1 = rs
//   alusrcb            00 = rt, 01 = 4, 10 = simm, 11 = simm << 2
//   aluop              00 = add, 01 = sub, 10 = funct, 11 = immediate op
//   pcsource           00 = ALU result, 01 = ALUOut, 10 = jump target
//   illegal_op         sticky trap flag, cleared only by reset
//   state              current state, for debug
module multicycle_control #(
    parameter int unsigned OPCODE_W      = 6,
    parameter int unsigned STATE_W       = 4,
    parameter int unsigned MEM_HANDSHAKE = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pcwrite,
    output logic                pcwritecond,
    output logic                iord,
    output logic                memread,
    output logic                memwrite,
    output logic                irwrite,
    output logic                memtoreg,
    output logic [1:0]          regdst,
    output logic                regwrite,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          aluop,
    output logic [1:0]          pcsource,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IEXEC   = 4'd10,
        S_IWB     = 4'd11,
        S_JAL     = 4'd12,
        S_ILLEGAL = 4'd13
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'b000011);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b001010);
    localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(6'b001111);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_done_c;

    // The branch decision is made in the datapath from pcwritecond & zero.
    logic   unused_zero;
    assign unused_zero = zero;

    // A memory access completes on mem_ready, or every cycle without the handshake.
    assign mem_done_c = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // State and trap flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_done_c) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_RTYPE) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_JAL) begin
                    state_d = S_JAL;
                end else if (opcode == OP_ADDI || opcode == OP_ANDI ||
                             opcode == OP_ORI  || opcode == OP_SLTI ||
                             opcode == OP_LUI) begin
                    state_d = S_IEXEC;
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_done_c) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (mem_done_c) state_d = S_FETCH;
            end
            S_EXEC:    state_d = S_RWB;
            S_IEXEC:   state_d = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JAL:
                       state_d = S_FETCH;
            S_ILLEGAL: state_d = S_ILLEGAL;
            // Encodings 14 and 15 are unreachable; recover into the trap.
            default:   state_d = S_ILLEGAL;
        endcase
    end

    // The flag rises together with entry into ILLEGAL and then stays set.
    always_comb begin
        illegal_d = illegal_q;
        if (state_d == S_ILLEGAL) illegal_d = 1'b1;
    end

    // Moore output decode; only FETCH's IR/PC loads look at the handshake.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 2'b00;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        illegal_op  = illegal_q;
        unique case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_done_c;
                pcwrite = mem_done_c;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 2'b01;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
            end
            S_IWB: begin
                regwrite = 1'b1;
            end
            S_JAL: begin
                regwrite = 1'b1;
                regdst   = 2'b10;
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            default: begin
            end
        endcase
        // Reset blanks every strobe so an aborted access cannot commit.
        if (reset) begin
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            iord        = 1'b0;
            memread     = 1'b0;
            memwrite    = 1'b0;
            irwrite     = 1'b0;
            memtoreg    = 1'b0;
            regdst      = 2'b00;
            regwrite    = 1'b0;
            alusrca     = 1'b0;
            alusrcb     = 2'b00;
            aluop       = 2'b00;
            pcsource    = 2'b00;
            illegal_op  = 1'b0;
        end
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: one instance with the memory handshake, one
// without. Instructions are expanded into the expected per-cycle state list from
// the instruction class, and each cycle's outputs are compared with that state's
// output table.
module tb_multicycle_control;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pcwrite_h, pcwritecond_h, iord_h, memread_h, memwrite_h, irwrite_h;
    logic       memtoreg_h, regwrite_h, alusrca_h, illegal_op_h;
    logic [1:0] regdst_h, alusrcb_h, aluop_h, pcsource_h;
    logic [3:0] state_h;

    logic       pcwrite_n, pcwritecond_n, iord_n, memread_n, memwrite_n, irwrite_n;
    logic       memtoreg_n, regwrite_n, alusrca_n, illegal_op_n;
    logic [1:0] regdst_n, alusrcb_n, aluop_n, pcsource_n;
    logic [3:0] state_n;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int st;
        bit rdy;
    } step_t;

    step_t q[$];

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                   6'b000010, 6'b000011, 6'b001000, 6'b001100,
                                   6'b001101, 6'b001111};

    multicycle_control #(.OPCODE_W(6), .STATE_W(4), .MEM_HANDSHAKE(1)) dut_h (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pcwrite(pcwrite_h), .pcwritecond(pcwritecond_h), .iord(iord_h),
        .memread(memread_h), .memwrite(memwrite_h), .irwrite(irwrite_h),
        .memtoreg(memtoreg_h), .regdst(regdst_h), .regwrite(regwrite_h),
        .alusrca(alusrca_h), .alusrcb(alusrcb_h), .aluop(aluop_h),
        .pcsource(pcsource_h), .illegal_op(illegal_op_h), .state(state_h)
    );

    multicycle_control #(.OPCODE_W(6), .STATE_W(4), .MEM_HANDSHAKE(0)) dut_n (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pcwrite(pcwrite_n), .pcwritecond(pcwritecond_n), .iord(iord_n),
        .memread(memread_n), .memwrite(memwrite_n), .irwrite(irwrite_n),
        .memtoreg(memtoreg_n), .regdst(regdst_n), .regwrite(regwrite_n),
        .alusrca(alusrca_n), .alusrcb(alusrcb_n), .aluop(aluop_n),
        .pcsource(pcsource_n), .illegal_op(illegal_op_n), .state(state_n)
    );

    wire [17:0] obs_h = {pcwrite_h, pcwritecond_h, iord_h, memread_h, memwrite_h, irwrite_h,
                         memtoreg_h, regdst_h, regwrite_h, alusrca_h, alusrcb_h, aluop_h,
                         pcsource_h, illegal_op_h};
    wire [17:0] obs_n = {pcwrite_n, pcwritecond_n, iord_n, memread_n, memwrite_n, irwrite_n,
                         memtoreg_n, regdst_n, regwrite_n, alusrca_n, alusrcb_n, aluop_n,
                         pcsource_n, illegal_op_n};

    always #5 clock = ~clock;

    // Output table of the controller, one row per state.
    function automatic logic [17:0] exp_vec(input int st, input bit done);
        logic pw, pwc, io, mr, mw, irw, m2r, rw, asa, ill;
        logic [1:0] rd, asb, aop, psrc;
        {pw, pwc, io, mr, mw, irw, m2r, rw, asa, ill} = '0;
        {rd, asb, aop, psrc} = '0;
        case (st)
            0:  begin mr = 1; asb = 2'b01; pw = done; irw = done; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 2'b01; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            9:  begin pw = 1; psrc = 2'b10; end
            10: begin asa = 1; asb = 2'b10; aop = 2'b11; end
            11: rw = 1;
            12: begin rw = 1; rd = 2'b10; pw = 1; psrc = 2'b10; end
            13: ill = 1;
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check the selected instance, advance one clock.
    task automatic step(input bit hs, input int st, input logic [5:0] op_drv, input bit rdy);
        opcode    = op_drv;
        mem_ready = hs ? rdy : 1'($urandom);
        zero      = 1'($urandom);
        #1;
        if (hs) begin
            check($sformatf("state_h(exp %0d)", st), 32'(state_h), 32'(st));
            check($sformatf("outs_h(st %0d)", st), 32'(obs_h), 32'(exp_vec(st, rdy)));
        end else begin
            check($sformatf("state_n(exp %0d)", st), 32'(state_n), 32'(st));
            check($sformatf("outs_n(st %0d)", st), 32'(obs_n), 32'(exp_vec(st, 1'b1)));
        end
        @(posedge clock);
        #1;
    endtask

    // Assert reset between edges, check both instances are blanked, release in FETCH.
    task automatic reset_pulse();
        reset = 1'b1;
        #1;
        check("rst_outs_h", 32'(obs_h), 32'd0);
        check("rst_state_h", 32'(state_h), 32'd0);
        check("rst_outs_n", 32'(obs_n), 32'd0);
        check("rst_state_n", 32'(state_n), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic push(input int st, input bit rdy);
        step_t s;
        s.st  = st;
        s.rdy = rdy;
        q.push_back(s);
    endtask

    // Expand one instruction into its expected cycle sequence, then run it.
    task automatic run_instr(input bit hs, input logic [5:0] op, input int fw, input int mw);
        bool_illegal: begin end
        q.delete();
        if (!hs) begin
            fw = 0;
            mw = 0;
        end
        for (int i = 0; i < fw; i++) push(0, 1'b0);
        push(0, 1'b1);
        push(1, 1'($urandom));
        case (op)
            6'b000000: begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
            6'b100011: begin
                push(2, 1'($urandom));
                for (int i = 0; i < mw; i++) push(3, 1'b0);
                push(3, 1'b1);
                push(4, 1'($urandom));
            end
            6'b101011: begin
                push(2, 1'($urandom));
                for (int i = 0; i < mw; i++) push(5, 1'b0);
                push(5, 1'b1);
            end
            6'b000100: push(8, 1'($urandom));
            6'b000010: push(9, 1'($urandom));
            6'b000011: push(12, 1'($urandom));
            6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111: begin
                push(10, 1'($urandom));
                push(11, 1'($urandom));
            end
            default: for (int i = 0; i < 20; i++) push(13, 1'($urandom));
        endcase
        foreach (q[i]) begin
            // The opcode is only meaningful once the IR has been loaded.
            step(hs, q[i].st, (q[i].st == 0) ? 6'($urandom) : op, q[i].rdy);
        end
        if (q[q.size()-1].st == 13) reset_pulse();
    endtask

    function automatic logic [5:0] pick_op();
        int idx = $urandom_range(0, 12);
        if (idx < 10) return legal_ops[idx];
        return 6'($urandom);
    endfunction

    initial begin
        clock     = 1'b0;
        reset     = 1'b1;
        opcode    = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #12;
        reset_pulse();

        // Reset while a store is waiting for memory.
        step(1, 0, 6'd0, 1'b1);
        step(1, 1, 6'b101011, 1'b0);
        step(1, 2, 6'b101011, 1'b1);
        step(1, 5, 6'b101011, 1'b0);
        step(1, 5, 6'b101011, 1'b0);
        mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("abort_outs", 32'(obs_h), 32'd0);
        check("abort_state", 32'(state_h), 32'd0);
        @(posedge clock);
        #1;
        check("abort_hold_outs", 32'(obs_h), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 0, 6'b101011, 1'b0);
        run_instr(1, 6'b100011, 0, 1);

        // Handshake instance: directed cases.
        run_instr(1, 6'b000000, 3, 0);
        run_instr(1, 6'b000100, 0, 0);
        run_instr(1, 6'b000100, 1, 0);
        run_instr(1, 6'b000011, 0, 0);
        run_instr(1, 6'b001101, 2, 0);
        run_instr(1, 6'b001010, 0, 0);
        run_instr(1, 6'b101011, 1, 3);
        run_instr(1, 6'b111111, 0, 0);
        for (int i = 0; i < 120; i++)
            run_instr(1, pick_op(), $urandom_range(0, 2), $urandom_range(0, 3));

        // No-handshake instance: fixed latencies.
        reset_pulse();
        run_instr(0, 6'b100011, 0, 0);
        run_instr(0, 6'b101011, 0, 0);
        run_instr(0, 6'b000100, 0, 0);
        run_instr(0, 6'b000010, 0, 0);
        run_instr(0, 6'b000011, 0, 0);
        run_instr(0, 6'b001111, 0, 0);
        run_instr(0, 6'b010001, 0, 0);
        for (int i = 0; i < 120; i++) run_instr(0, pick_op(), 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle opcode decoder: a Moore FSM sequencing each MIPS instruction over 3-5 states.
- Drives the shared-memory multicycle datapath: PC, IR, register file, ALU muxes and memory port.
- Adds an optional memory ready handshake, wider immediate-instruction coverage and jal link write.
- Unknown opcodes are trapped.

Parameters:
- OPCODE_W, 6: opcode width. Values below assume 6.
- STATE_W, 4: state register width. Must be at least 4.
- MEM_HANDSHAKE, 1:
  - 1: memory states wait for mem_ready.
  - 0: memory states advance after one cycle and mem_ready is ignored.

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high.
- opcode, in, OPCODE_W: IR[31:26], valid from DECODE onward.
- zero, in, 1: ALU zero flag.
- mem_ready, in, 1: memory access completes this cycle.
- pcwrite, out, 1: unconditional PC load.
- pcwritecond, out, 1: PC load qualified by zero.
- iord, out, 1: memory address source. 0 = PC, 1 = ALUOut.
- memread, out, 1: memory read strobe.
- memwrite, out, 1: memory write strobe.
- irwrite, out, 1: IR load.
- memtoreg, out, 1: write-back source is MDR.
- regdst, out, 2: destination register. 00 = rt, 01 = rd, 10 = $31.
- regwrite, out, 1: register file write enable.
- alusrca, out, 1: ALU A source. 0 = PC, 1 = rs.
- alusrcb, out, 2: ALU B source. 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- aluop, out, 2: 00 = add, 01 = subtract, 10 = funct-decoded, 11 = opcode-decoded immediate op.
- pcsource, out, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op, out, 1: sticky trap flag.
- state, out, STATE_W: current state, for debug.

Behaviour:
- Reset:
  - Asynchronous, active-high. State goes to FETCH and illegal_op clears.
  - While reset is high, every output except state is forced to 0.
  - Reset in any state, including mid-memory-wait, aborts the instruction. No partial write is committed after reset deasserts.
- Outputs are decoded from state only (Moore), except pcwrite and irwrite in FETCH, which are qualified by the handshake.
- Any output not listed for a state is 0.
- States (encoding) and asserted outputs:
  - FETCH (0): memread, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00. irwrite and pcwrite assert only on the completing cycle. Completing cycle = mem_ready=1, or always when MEM_HANDSHAKE=0.
  - DECODE (1): alusrca=0, alusrcb=11, aluop=00. Computes the branch target.
  - MEMADR (2): alusrca=1, alusrcb=10, aluop=00.
  - MEMRD (3): memread, iord=1.
  - MEMWB (4): regwrite, memtoreg, regdst=00.
  - MEMWR (5): memwrite, iord=1.
  - EXEC (6): alusrca=1, alusrcb=00, aluop=10.
  - RWB (7): regwrite, regdst=01.
  - BRANCH (8): alusrca=1, alusrcb=00, aluop=01, pcwritecond, pcsource=01.
  - JUMP (9): pcwrite, pcsource=10.
  - IEXEC (10): alusrca=1, alusrcb=10, aluop=11.
  - IWB (11): regwrite, regdst=00.
  - JAL (12): regwrite, regdst=10, pcwrite, pcsource=10. Writes PC+4 (already in PC) via the datapath link path.
  - ILLEGAL (13): illegal_op=1, no enables.
- Transitions:
  - FETCH to DECODE on the completing cycle. Otherwise hold; all strobes stay stable while waiting.
  - DECODE dispatches on opcode:
    - 000000 to EXEC.
    - 100011 or 101011 to MEMADR.
    - 000100 to BRANCH.
    - 000010 to JUMP.
    - 000011 to JAL.
    - 001000, 001100, 001101, 001010, 001111 (addi, andi, ori, slti, lui) to IEXEC.
    - Anything else to ILLEGAL.
  - MEMADR goes to MEMRD for opcode 100011, else to MEMWR.
  - MEMRD goes to MEMWB on completion, otherwise holds.
  - MEMWR goes to FETCH on completion, otherwise holds.
  - EXEC to RWB. IEXEC to IWB.
  - MEMWB, RWB, IWB, BRANCH, JUMP and JAL all go to FETCH.
  - ILLEGAL holds until reset; illegal_op stays 1.
  - Unused encodings 14-15 go to ILLEGAL on the next edge.
- Instruction latency with MEM_HANDSHAKE=0 (cycles):
  - lw 5.
  - sw, R-type and immediate ops 4.
  - beq, j and jal 3.
- Each memory wait cycle adds 1.
- opcode is sampled only in DECODE and MEMADR. The IR must not change outside FETCH's completing cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
- Reset asserted mid-MEMWR wait (mem_ready=0) -> all outputs 0 immediately, state=0. After release, FETCH with memread=1 and memwrite never pulses.
- MEM_HANDSHAKE=0, opcode 100011 -> state sequence 0,1,2,3,4,0. regwrite=1 with memtoreg=1 only in cycle 5. Total 5 cycles.
- MEM_HANDSHAKE=1, FETCH with mem_ready low for 3 cycles then high -> memread held 4 cycles. irwrite and pcwrite high only in cycle 4, then DECODE.
- opcode 000100 with zero=1, then repeat with zero=0 -> BRANCH asserts pcwritecond=1, aluop=01, pcsource=01 in both cases. Returns to FETCH after 3 cycles.
- opcode 000011 -> JAL asserts regwrite=1, regdst=10, pcwrite=1, pcsource=10 in the same cycle.
- opcode 001101 -> IEXEC with aluop=11, alusrcb=10, then IWB with regdst=00.
- opcode 111111 -> ILLEGAL, illegal_op=1 held for 20 cycles, cleared only by reset.
